// File: rtl/oport_credit_tracker_if.sv
// Bundle between the crossbar output stage, the VC/SW allocator and the credit tracker.
// The master side drives flits, credits and allocations; the slave side (tracker) reports status.
interface oport_credit_tracker_if #(
    parameter int unsigned V     = 4,
    parameter int unsigned P     = 5,
    parameter int unsigned B     = 4,
    parameter int unsigned Fpay  = 32,
    parameter int unsigned CONGw = 3
);
    localparam int unsigned Fw = 2 + V + Fpay;
    localparam int unsigned PV = P * V;
    localparam int unsigned Bw = $clog2(B + 1);

    logic [P*Fw-1:0]    flit_out_all;
    logic [P-1:0]       flit_out_we_all;
    logic [PV-1:0]      credit_in_all;
    logic [PV-1:0]      ovc_allocated_all;
    logic [PV-1:0]      ovc_not_full_all;
    logic [PV-1:0]      ovc_free_all;
    logic [PV*Bw-1:0]   credit_cnt_all;
    logic [P*CONGw-1:0] congestion_out_all;
    logic [PV-1:0]      credit_err_all;
    logic [PV-1:0]      alloc_err_all;

    modport master (
        output flit_out_all, flit_out_we_all, credit_in_all, ovc_allocated_all,
        input  ovc_not_full_all, ovc_free_all, credit_cnt_all, congestion_out_all,
               credit_err_all, alloc_err_all
    );

    modport slave (
        input  flit_out_all, flit_out_we_all, credit_in_all, ovc_allocated_all,
        output ovc_not_full_all, ovc_free_all, credit_cnt_all, congestion_out_all,
               credit_err_all, alloc_err_all
    );
endinterface

// File: rtl/oport_credit_tracker.sv
// Per-port, per-VC downstream credit counter and OVC ownership tracker with registered
// congestion level and sticky protocol-error flags.
module oport_credit_tracker #(
    parameter int unsigned V         = 4,
    parameter int unsigned P         = 5,
    parameter int unsigned B         = 4,
    parameter int unsigned Fpay      = 32,
    parameter int unsigned NF_MARGIN = 0,
    parameter int unsigned CONGw     = 3
) (
    input logic                   clk_i,
    input logic                   reset_i,
    oport_credit_tracker_if.slave bus_io
);
    localparam int unsigned Fw      = 2 + V + Fpay;
    localparam int unsigned PV      = P * V;
    localparam int unsigned Bw      = $clog2(B + 1);
    localparam int unsigned CongMax = (1 << CONGw) - 1;

    typedef enum logic [0:0] {StFree, StBusy} ovc_state_e;

    logic [Bw-1:0]      cnt_q [PV];
    logic [Bw-1:0]      cnt_d [PV];
    ovc_state_e         st_q  [PV];
    ovc_state_e         st_d  [PV];
    logic [PV-1:0]      cerr_q, cerr_d;
    logic [PV-1:0]      aerr_q, aerr_d;
    logic [P*CONGw-1:0] cong_q, cong_d;
    logic [PV-1:0]      nf;

    // Header and payload bits pass through the tracker untouched.
    logic unused_flit;
    assign unused_flit = ^bus_io.flit_out_all;

    always_comb begin
        logic [V-1:0] vcf;
        logic         tail, bad, dec, inc, alloc, tail_sent;
        int unsigned  i;
        vcf       = '0;
        tail      = 1'b0;
        bad       = 1'b0;
        dec       = 1'b0;
        inc       = 1'b0;
        alloc     = 1'b0;
        tail_sent = 1'b0;
        i         = 0;
        cnt_d     = cnt_q;
        st_d      = st_q;
        cerr_d    = cerr_q;
        aerr_d    = aerr_q;
        for (int unsigned p = 0; p < P; p++) begin
            vcf  = bus_io.flit_out_all[p*Fw + Fw - 3 -: V];
            tail = bus_io.flit_out_all[p*Fw + Fw - 2];
            bad  = bus_io.flit_out_we_all[p] & ~$onehot(vcf);
            for (int unsigned v = 0; v < V; v++) begin
                i         = p * V + v;
                dec       = bus_io.flit_out_we_all[p] & $onehot(vcf) & vcf[v];
                inc       = bus_io.credit_in_all[i];
                alloc     = bus_io.ovc_allocated_all[i];
                tail_sent = dec & tail;
                if (bad) cerr_d[i] = 1'b1;
                if (dec && !inc) begin
                    if (cnt_q[i] == '0) cerr_d[i] = 1'b1;
                    else                cnt_d[i]  = cnt_q[i] - Bw'(1);
                end else if (inc && !dec) begin
                    if (cnt_q[i] == Bw'(B)) cerr_d[i] = 1'b1;
                    else                    cnt_d[i]  = cnt_q[i] + Bw'(1);
                end
                unique case (st_q[i])
                    StFree: begin
                        if (alloc)          st_d[i]   = StBusy;
                        else if (tail_sent) aerr_d[i] = 1'b1;
                    end
                    StBusy: begin
                        // A same-cycle tail closes the old packet, so the new grant is legal.
                        if (alloc) begin
                            if (!tail_sent) aerr_d[i] = 1'b1;
                        end else if (tail_sent) begin
                            st_d[i] = StFree;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < PV; i++) begin
            nf[i] = cnt_q[i] > Bw'(NF_MARGIN);
        end
    end

    always_comb begin
        int unsigned lvl;
        lvl    = 0;
        cong_d = '0;
        for (int unsigned p = 0; p < P; p++) begin
            lvl = 0;
            for (int unsigned v = 0; v < V; v++) begin
                lvl = lvl + 32'(!nf[p*V + v]) + 32'(st_q[p*V + v] == StBusy);
            end
            cong_d[p*CONGw +: CONGw] = (lvl > CongMax) ? CONGw'(CongMax) : CONGw'(lvl);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < PV; i++) begin
                cnt_q[i] <= Bw'(B);
                st_q[i]  <= StFree;
            end
            cerr_q <= '0;
            aerr_q <= '0;
            cong_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            cerr_q <= cerr_d;
            aerr_q <= aerr_d;
            cong_q <= cong_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < PV; i++) begin
            bus_io.credit_cnt_all[i*Bw +: Bw] = cnt_q[i];
            bus_io.ovc_free_all[i]            = (st_q[i] == StFree);
        end
    end

    assign bus_io.ovc_not_full_all   = nf;
    assign bus_io.credit_err_all     = cerr_q;
    assign bus_io.alloc_err_all      = aerr_q;
    assign bus_io.congestion_out_all = cong_q;
endmodule

// File: tb/tb_oport_credit_tracker.sv
// Bench for oport_credit_tracker: directed vector table, congestion and reset sequences,
// then random traffic against a counting reference model.
module tb_oport_credit_tracker;
    localparam int V = 4, P = 5, B = 4, FPAY = 32, CONGW = 3, NF = 0;
    localparam int FW = 2 + V + FPAY, PV = P * V, BW = 3;

    logic clk = 1'b0, reset = 1'b1, rst_m = 1'b1;
    always #5 clk = ~clk;

    oport_credit_tracker_if #(.V(V), .P(P), .B(B), .Fpay(FPAY), .CONGw(CONGW)) bus ();
    oport_credit_tracker_if #(.V(V), .P(P), .B(B), .Fpay(FPAY), .CONGw(CONGW)) bus_m ();

    oport_credit_tracker #(.V(V), .P(P), .B(B), .Fpay(FPAY), .NF_MARGIN(0), .CONGw(CONGW))
        u_dut (.clk_i(clk), .reset_i(reset), .bus_io(bus));
    oport_credit_tracker #(.V(V), .P(P), .B(B), .Fpay(FPAY), .NF_MARGIN(1), .CONGw(CONGW))
        u_dut_m (.clk_i(clk), .reset_i(rst_m), .bus_io(bus_m));

    int checks = 0, errors = 0;

    // Stimulus for the main DUT
    logic [P-1:0]  we;
    logic [V-1:0]  vcf [P];
    logic          tl  [P];
    logic [PV-1:0] cred, alloc;

    // Reference model: plain counts and open-packet flags
    int m_cnt [PV];
    int m_open[PV];
    bit m_cerr[PV], m_aerr[PV];
    int m_cong[P];

    typedef struct {
        string    name;
        int       port;
        bit       we;
        bit [3:0] vcf;
        bit       tail;
        int       cred_idx;
        int       alloc_idx;
        int       chk_idx;
        int       e_cnt;
        bit       e_free, e_nf, e_cerr, e_aerr;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        we = '0; cred = '0; alloc = '0;
        for (int p = 0; p < P; p++) begin vcf[p] = '0; tl[p] = 1'b0; end
    endtask

    task automatic drive();
        logic [FW-1:0] f;
        for (int p = 0; p < P; p++) begin
            f = {1'b0, tl[p], vcf[p], 32'($urandom)};
            bus.flit_out_all[p*FW +: FW] = f;
        end
        bus.flit_out_we_all   = we;
        bus.credit_in_all     = cred;
        bus.ovc_allocated_all = alloc;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < PV; i++) begin
            m_cnt[i] = B; m_open[i] = 0; m_cerr[i] = 0; m_aerr[i] = 0;
        end
        for (int p = 0; p < P; p++) m_cong[p] = 0;
    endfunction

    function automatic void model_step();
        int lvl, n, dec, ts;
        bit bad;
        for (int p = 0; p < P; p++) begin
            lvl = 0;
            for (int v = 0; v < V; v++)
                lvl += m_open[p*V+v] + ((m_cnt[p*V+v] <= NF) ? 1 : 0);
            m_cong[p] = (lvl > 7) ? 7 : lvl;
        end
        for (int p = 0; p < P; p++) begin
            bad = we[p] && ($countones(vcf[p]) != 1);
            for (int v = 0; v < V; v++) begin
                int i;
                i   = p * V + v;
                dec = (we[p] && !bad && vcf[p][v]) ? 1 : 0;
                if (bad) m_cerr[i] = 1;
                n = m_cnt[i] + int'(cred[i]) - dec;
                if (n < 0) begin n = 0; m_cerr[i] = 1; end
                if (n > B) begin n = B; m_cerr[i] = 1; end
                m_cnt[i] = n;
                ts = (dec == 1 && tl[p]) ? 1 : 0;
                if (alloc[i] && ts == 1) m_open[i] = 1;
                else begin
                    n = m_open[i] - ts + int'(alloc[i]);
                    if (n > 1) begin n = 1; m_aerr[i] = 1; end
                    if (n < 0) begin n = 0; m_aerr[i] = 1; end
                    m_open[i] = n;
                end
            end
        end
    endfunction

    task automatic check_all(input string tag);
        logic [PV*BW-1:0]   e_cnt;
        logic [PV-1:0]      e_free, e_nf, e_cerr, e_aerr;
        logic [P*CONGW-1:0] e_cong;
        for (int i = 0; i < PV; i++) begin
            e_cnt[i*BW +: BW] = m_cnt[i][BW-1:0];
            e_free[i] = (m_open[i] == 0);
            e_nf[i]   = (m_cnt[i] > NF);
            e_cerr[i] = m_cerr[i];
            e_aerr[i] = m_aerr[i];
        end
        for (int p = 0; p < P; p++) e_cong[p*CONGW +: CONGW] = m_cong[p][CONGW-1:0];
        chk({tag, " credit_cnt"}, 64'(bus.credit_cnt_all), 64'(e_cnt));
        chk({tag, " ovc_free"},   64'(bus.ovc_free_all), 64'(e_free));
        chk({tag, " not_full"},   64'(bus.ovc_not_full_all), 64'(e_nf));
        chk({tag, " credit_err"}, 64'(bus.credit_err_all), 64'(e_cerr));
        chk({tag, " alloc_err"},  64'(bus.alloc_err_all), 64'(e_aerr));
        chk({tag, " congestion"}, 64'(bus.congestion_out_all), 64'(e_cong));
    endtask

    task automatic tick(input string tag);
        drive();
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic vec_t mk(string nm, int port, bit w, bit [3:0] vf, bit t, int ci, int ai,
                                int ck, int ec, bit ef, bit en, bit ece, bit eae);
        vec_t r;
        r.name = nm; r.port = port; r.we = w; r.vcf = vf; r.tail = t; r.cred_idx = ci;
        r.alloc_idx = ai; r.chk_idx = ck; r.e_cnt = ec; r.e_free = ef; r.e_nf = en;
        r.e_cerr = ece; r.e_aerr = eae;
        return r;
    endfunction

    task automatic m_flit(input logic [3:0] v, input bit a, input bit c);
        bus_m.flit_out_all            = '0;
        bus_m.flit_out_all[FW-3 -: V] = v;
        bus_m.flit_out_we_all         = (v != 0) ? 5'b00001 : 5'b00000;
        bus_m.ovc_allocated_all       = a ? 20'h1 : 20'h0;
        bus_m.credit_in_all           = c ? 20'h1 : 20'h0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [PV*BW-1:0] all4;
        clear_in();
        drive();
        model_reset();
        bus_m.flit_out_all = '0; bus_m.flit_out_we_all = '0;
        bus_m.credit_in_all = '0; bus_m.ovc_allocated_all = '0;
        for (int i = 0; i < PV; i++) all4[i*BW +: BW] = 3'd4;

        // Reset state against constants and model
        @(posedge clk); #1;
        chk("reset credit_cnt", 64'(bus.credit_cnt_all), 64'(all4));
        chk("reset ovc_free", 64'(bus.ovc_free_all), 64'hFFFFF);
        chk("reset errors", 64'({bus.credit_err_all, bus.alloc_err_all}), 64'h0);
        check_all("reset");
        reset = 1'b0; rst_m = 1'b0;

        // Directed vector table (state accumulates row to row)
        vecs.push_back(mk("t2 alloc",     1, 0, 4'b0000, 0, -1,  6,  6, 4, 0, 1, 0, 0));
        vecs.push_back(mk("t2 hdr",       1, 1, 4'b0100, 0, -1, -1,  6, 3, 0, 1, 0, 0));
        vecs.push_back(mk("t2 body1",     1, 1, 4'b0100, 0, -1, -1,  6, 2, 0, 1, 0, 0));
        vecs.push_back(mk("t2 body2",     1, 1, 4'b0100, 0, -1, -1,  6, 1, 0, 1, 0, 0));
        vecs.push_back(mk("t2 tail",      1, 1, 4'b0100, 1, -1, -1,  6, 0, 1, 0, 0, 0));
        vecs.push_back(mk("t3 alloc+flit",0, 1, 4'b0001, 0, -1,  0,  0, 3, 0, 1, 0, 0));
        vecs.push_back(mk("t3 flit",      0, 1, 4'b0001, 0, -1, -1,  0, 2, 0, 1, 0, 0));
        vecs.push_back(mk("t3 flit+cred", 0, 1, 4'b0001, 0,  0, -1,  0, 2, 0, 1, 0, 0));
        vecs.push_back(mk("t3 cred1",     0, 0, 4'b0000, 0,  0, -1,  0, 3, 0, 1, 0, 0));
        vecs.push_back(mk("t3 cred2",     0, 0, 4'b0000, 0,  0, -1,  0, 4, 0, 1, 0, 0));
        vecs.push_back(mk("t3 overflow",  0, 0, 4'b0000, 0,  0, -1,  0, 4, 0, 1, 1, 0));
        vecs.push_back(mk("t3 sticky",    0, 0, 4'b0000, 0, -1, -1,  0, 4, 0, 1, 1, 0));
        vecs.push_back(mk("t4 alloc",     3, 0, 4'b0000, 0, -1, 13, 13, 4, 0, 1, 0, 0));
        vecs.push_back(mk("t4 tail+alloc",3, 1, 4'b0010, 1, -1, 13, 13, 3, 0, 1, 0, 0));
        vecs.push_back(mk("t4 busy alloc",3, 0, 4'b0000, 0, -1, 13, 13, 3, 0, 1, 0, 1));
        vecs.push_back(mk("tail on free", 1, 1, 4'b1000, 1, -1, -1,  7, 3, 1, 1, 0, 1));
        vecs.push_back(mk("bad vc v0",    4, 1, 4'b0011, 0, -1, -1, 16, 4, 1, 1, 1, 0));
        vecs.push_back(mk("bad vc v3",    4, 0, 4'b0000, 0, -1, -1, 19, 4, 1, 1, 1, 0));
        for (int k = 0; k < vecs.size(); k++) begin
            int ix;
            clear_in();
            we[vecs[k].port]  = vecs[k].we;
            vcf[vecs[k].port] = vecs[k].vcf;
            tl[vecs[k].port]  = vecs[k].tail;
            if (vecs[k].cred_idx >= 0)  cred[vecs[k].cred_idx] = 1'b1;
            if (vecs[k].alloc_idx >= 0) alloc[vecs[k].alloc_idx] = 1'b1;
            tick(vecs[k].name);
            ix = vecs[k].chk_idx;
            chk({"vec ", vecs[k].name},
                64'({bus.credit_cnt_all[ix*BW +: BW], bus.ovc_free_all[ix],
                     bus.ovc_not_full_all[ix], bus.credit_err_all[ix], bus.alloc_err_all[ix]}),
                64'({3'(vecs[k].e_cnt), vecs[k].e_free, vecs[k].e_nf, vecs[k].e_cerr,
                     vecs[k].e_aerr}));
        end

        // Congestion on port 2: three busy VCs, two drained to zero credits
        clear_in();
        alloc[8] = 1'b1; alloc[9] = 1'b1; alloc[10] = 1'b1;
        tick("t5 alloc");
        for (int n = 0; n < 8; n++) begin
            clear_in();
            we[2] = 1'b1;
            vcf[2] = (n < 4) ? 4'b0001 : 4'b0010;
            tick("t5 drain");
        end
        chk("t5 congestion lag", 64'(bus.congestion_out_all[8:6]), 64'd4);
        clear_in();
        tick("t5 idle");
        chk("t5 congestion", 64'(bus.congestion_out_all[8:6]), 64'd5);

        // NF_MARGIN=1 instance, then async reset mid-packet and a stale credit
        m_flit(4'b0001, 1'b1, 1'b0);
        m_flit(4'b0001, 1'b0, 1'b0);
        chk("t6 nf at cnt2", 64'({bus_m.credit_cnt_all[2:0], bus_m.ovc_not_full_all[0]}),
            64'({3'd2, 1'b1}));
        m_flit(4'b0001, 1'b0, 1'b0);
        chk("t6 nf at cnt1", 64'({bus_m.credit_cnt_all[2:0], bus_m.ovc_not_full_all[0]}),
            64'({3'd1, 1'b0}));
        #2 rst_m = 1'b1;
        #1;
        chk("t6 async reset", 64'({bus_m.credit_cnt_all[2:0], bus_m.ovc_free_all[0],
                                   bus_m.ovc_not_full_all[0]}), 64'({3'd4, 1'b1, 1'b1}));
        #1 rst_m = 1'b0;
        m_flit(4'b0000, 1'b0, 1'b1);
        chk("t6 stale credit", 64'({bus_m.credit_cnt_all[2:0], bus_m.credit_err_all[0]}),
            64'({3'd4, 1'b1}));

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            clear_in();
            for (int p = 0; p < P; p++) begin
                we[p]  = 1'($urandom_range(0, 1));
                vcf[p] = ($urandom_range(0, 15) == 0) ? 4'($urandom) :
                         4'(1 << $urandom_range(0, V - 1));
                tl[p]  = ($urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < PV; i++) begin
                cred[i]  = ($urandom_range(0, 5) == 0);
                alloc[i] = ($urandom_range(0, 9) == 0);
            end
            tick("rand");
        end

        // Async reset of the main DUT mid-cycle, then an in-flight credit after release
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("mid reset");
        #1 reset = 1'b0;
        clear_in();
        cred[5] = 1'b1;
        tick("post reset credit");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
